// File: rtl/pos_truth_sweeper.sv
// pos_truth_sweeper
//
// Sequential stimulus/checker stage for a 4-input PoS function block. The block
// inputs {A,B,C,D} are stepped through indices 0..15 in ascending order. Each
// vector is held for SETTLE_CYCLES cycles in SETTLE and one cycle in SAMPLE.
// The block output f_in is captured on the edge that leaves SAMPLE. The
// captured truth table is compared bit by bit against an expected table that is
// latched at start. The result is reported with a one-cycle done pulse.
//
// Ports
//   clk             single clock, rising edge
//   rst_n           asynchronous active-low reset
//   start           sweep request, accepted only while idle
//   exp_table[15:0] expected table, bit i = f for index i = {A,B,C,D}
//   f_in            output f of the PoS block under test
//   A, B, C, D      PoS block inputs (A is the MSB of the index)
//   busy            high while a vector is driven (SETTLE / SAMPLE)
//   done            one-cycle pulse in FINISH
//   pass            captured table matched the latched expected table
//   captured[15:0]  sampled truth table, same ordering as exp_table
//   err_count[4:0]  number of mismatching indices, 0..16
//   first_err[3:0]  lowest mismatching index
//   first_err_valid at least one mismatch was seen
//
// Every output is a flop. The FSM and all result state update in one register
// block, and the next state is computed combinationally.

module pos_truth_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 1  // legal range 1..255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] exp_table,
    input  logic        f_in,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] captured,
    output logic [4:0]  err_count,
    output logic [3:0]  first_err,
    output logic        first_err_valid
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StSample = 2'd2,
        StFinish = 2'd3
    } state_e;

    // Counter reload value. SETTLE runs for cnt+1 cycles, so load S-1.
    localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] exp_q, exp_d;

    // Registered outputs
    logic [3:0]  vec_q, vec_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [15:0] cap_q, cap_d;
    logic [4:0]  err_q, err_d;
    logic [3:0]  fe_q, fe_d;
    logic        fev_q, fev_d;

    logic        mismatch;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        cap_d    = cap_q;
        err_d    = err_q;
        fe_d     = fe_q;
        fev_d    = fev_q;
        mismatch = (f_in != exp_q[idx_q]);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    exp_d   = exp_table;
                    cap_d   = 16'h0000;
                    err_d   = 5'd0;
                    fe_d    = 4'd0;
                    fev_d   = 1'b0;
                    pass_d  = 1'b0;
                    idx_d   = 4'd0;
                    cnt_d   = SettleLoad;
                    state_d = StSettle;
                end
            end

            StSettle: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = StSample;
                end
            end

            StSample: begin
                cap_d[idx_q] = f_in;
                if (mismatch) begin
                    err_d = err_q + 5'd1;
                    if (!fev_q) begin
                        fe_d  = idx_q;
                        fev_d = 1'b1;
                    end
                end
                if (idx_q == 4'd15) begin
                    // pass and done are registered on entry to FINISH. They use
                    // the count that already includes this last sample.
                    state_d = StFinish;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 5'd0);
                end else begin
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = SettleLoad;
                    state_d = StSettle;
                end
            end

            StFinish: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // The vector and busy outputs follow the state being entered. This keeps
        // them registered and still aligned with the SETTLE/SAMPLE cycles.
        busy_d = (state_d == StSettle) || (state_d == StSample);
        vec_d  = busy_d ? idx_d : 4'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 4'd0;
            cnt_q   <= 8'd0;
            exp_q   <= 16'h0000;
            vec_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            cap_q   <= 16'h0000;
            err_q   <= 5'd0;
            fe_q    <= 4'd0;
            fev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
            fe_q    <= fe_d;
            fev_q   <= fev_d;
        end
    end

    assign A               = vec_q[3];
    assign B               = vec_q[2];
    assign C               = vec_q[1];
    assign D               = vec_q[0];
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign captured        = cap_q;
    assign err_count       = err_q;
    assign first_err       = fe_q;
    assign first_err_valid = fev_q;

endmodule

// File: tb/tb_pos_truth_sweeper.sv
// Directed bench for pos_truth_sweeper. It uses two instances, one with
// SETTLE_CYCLES=1 and one with SETTLE_CYCLES=3. The PoS block is modelled as a
// table lookup on the driven {A,B,C,D}. The model can also force f to stuck-at-0
// or stuck-at-1.

module tb_pos_truth_sweeper;

    localparam logic [15:0] Gold = 16'h7310;  // f=1 at 4,8,9,12,13,14

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   f_mode;  // 0 golden, 1 stuck-at-0, 2 stuck-at-1
    int   sel;     // which instance the observation mux looks at (1 or 3)

    logic        start1, start3;
    logic [15:0] exp1, exp3;
    logic        f1, f3;
    logic        a1, b1, c1, d1, busy1, done1, pass1, fev1;
    logic        a3, b3, c3, d3, busy3, done3, pass3, fev3;
    logic [15:0] cap1, cap3;
    logic [4:0]  ec1, ec3;
    logic [3:0]  fe1, fe3;

    pos_truth_sweeper #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .exp_table(exp1), .f_in(f1),
        .A(a1), .B(b1), .C(c1), .D(d1), .busy(busy1), .done(done1), .pass(pass1),
        .captured(cap1), .err_count(ec1), .first_err(fe1), .first_err_valid(fev1)
    );

    pos_truth_sweeper #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .exp_table(exp3), .f_in(f3),
        .A(a3), .B(b3), .C(c3), .D(d3), .busy(busy3), .done(done3), .pass(pass3),
        .captured(cap3), .err_count(ec3), .first_err(fe3), .first_err_valid(fev3)
    );

    function automatic logic pos_model(input int mode, input logic [3:0] i);
        logic [15:0] t;
        t = Gold;
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        return t[i];
    endfunction

    always_comb f1 = pos_model(f_mode, {a1, b1, c1, d1});
    always_comb f3 = pos_model(f_mode, {a3, b3, c3, d3});

    // Observation mux plus full output vectors for the reset checks
    logic [3:0]  obs_abcd;
    logic        obs_busy, obs_done, obs_pass, obs_fev;
    logic [15:0] obs_cap;
    logic [4:0]  obs_ec;
    logic [3:0]  obs_fe;
    logic [32:0] outs1, outs3;

    always_comb begin
        if (sel == 3) begin
            obs_abcd = {a3, b3, c3, d3}; obs_busy = busy3; obs_done = done3;
            obs_pass = pass3; obs_cap = cap3; obs_ec = ec3; obs_fe = fe3; obs_fev = fev3;
        end else begin
            obs_abcd = {a1, b1, c1, d1}; obs_busy = busy1; obs_done = done1;
            obs_pass = pass1; obs_cap = cap1; obs_ec = ec1; obs_fe = fe1; obs_fev = fev1;
        end
        outs1 = {a1, b1, c1, d1, busy1, done1, pass1, cap1, ec1, fe1, fev1};
        outs3 = {a3, b3, c3, d3, busy3, done3, pass3, cap3, ec3, fe3, fev3};
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start one sweep on instance s and follow it to one cycle past done.
    // Checks the per-cycle vector/busy/done trace and the cycle in which done
    // appears. With disturb set, start is pulsed and exp_table is inverted in
    // cycle 10, which is mid-sweep.
    task automatic run_sweep(input int s, input logic [15:0] tbl, input bit disturb,
                             input string tag);
        int bad;
        int done_cyc;
        int last;
        logic [3:0] ev;
        logic eb, ed;
        last     = 16 * (s + 1);
        bad      = 0;
        done_cyc = -1;
        sel      = s;
        @(negedge clk);
        if (s == 3) begin start3 = 1'b1; exp3 = tbl; end
        else begin start1 = 1'b1; exp1 = tbl; end
        @(posedge clk);  // edge 0
        #1;
        start1 = 1'b0;
        start3 = 1'b0;
        for (int n = 1; n <= last + 2; n++) begin
            @(negedge clk);  // inside cycle n
            if (disturb && n == 10) begin start3 = 1'b1; exp3 = ~tbl; end
            if (disturb && n == 11) start3 = 1'b0;
            if (n <= last) begin
                ev = 4'((n - 1) / (s + 1)); eb = 1'b1; ed = 1'b0;
            end else if (n == last + 1) begin
                ev = 4'd0; eb = 1'b0; ed = 1'b1;
            end else begin
                ev = 4'd0; eb = 1'b0; ed = 1'b0;
            end
            if (obs_abcd !== ev || obs_busy !== eb || obs_done !== ed) bad++;
            if (obs_done === 1'b1 && done_cyc < 0) done_cyc = n;
        end
        check({tag, "_trace_bad_cycles"}, 64'(bad), 64'd0);
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(last + 1));
    endtask

    task automatic check_result(input string tag, input logic p, input logic [15:0] cap,
                                input logic [4:0] ec, input logic [3:0] fe, input logic fev);
        check({tag, "_pass"}, 64'(obs_pass), 64'(p));
        check({tag, "_captured"}, 64'(obs_cap), 64'(cap));
        check({tag, "_err_count"}, 64'(obs_ec), 64'(ec));
        check({tag, "_first_err_valid"}, 64'(obs_fev), 64'(fev));
        if (fev) check({tag, "_first_err"}, 64'(obs_fe), 64'(fe));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        sel    = 1;
        f_mode = 0;
        rst_n  = 1'b0;
        start1 = 1'b0; start3 = 1'b0; exp1 = 16'h0; exp3 = 16'h0;

        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start1 = 1'($urandom); start3 = 1'($urandom);
            exp1 = 16'($urandom); exp3 = 16'($urandom);
            f_mode = int'($urandom_range(0, 2));
        end
        check("rst_outs_s1", 64'(outs1), 64'd0);
        check("rst_outs_s3", 64'(outs3), 64'd0);
        @(negedge clk);
        start1 = 1'b0; start3 = 1'b0; f_mode = 0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_outs_s1", 64'(outs1), 64'd0);
        check("idle_outs_s3", 64'(outs3), 64'd0);

        // Golden sweep, S=1
        f_mode = 0;
        run_sweep(1, Gold, 1'b0, "gold_s1");
        check_result("gold_s1", 1'b1, 16'h7310, 5'd0, 4'd0, 1'b0);
        check("gold_s1_first_err", 64'(obs_fe), 64'd0);

        // Stuck-at-0
        f_mode = 1;
        run_sweep(1, Gold, 1'b0, "sa0");
        check_result("sa0", 1'b0, 16'h0000, 5'd6, 4'd4, 1'b1);

        // Stuck-at-1. first_err must move from 4 back to 0.
        f_mode = 2;
        run_sweep(1, Gold, 1'b0, "sa1");
        check_result("sa1", 1'b0, 16'hFFFF, 5'd10, 4'd0, 1'b1);

        // Results hold in idle
        repeat (5) @(negedge clk);
        check("sa1_hold_err_count", 64'(obs_ec), 64'd10);

        // Protocol with S=3: the mid-sweep start and table change are ignored
        f_mode = 0;
        run_sweep(3, Gold, 1'b1, "proto_s3");
        check_result("proto_s3", 1'b1, 16'h7310, 5'd0, 4'd0, 1'b0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy3 !== 1'b0 || done3 !== 1'b0) bad++;
        end
        check("proto_s3_no_queued_start", 64'(bad), 64'd0);

        // Reset mid-sweep at idx 7, with stuck-at-0 so state is non-zero
        sel    = 1;
        f_mode = 1;
        @(negedge clk);
        start1 = 1'b1; exp1 = Gold;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (15) @(negedge clk);  // cycle 15: vector 7 in SETTLE
        check("mid_idx", 64'(obs_abcd), 64'd7);
        check("mid_err_nonzero", 64'(obs_ec), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_async_clear", 64'(outs1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (done1 !== 1'b0 || busy1 !== 1'b0) bad++;
        end
        check("mid_rst_no_done", 64'(bad), 64'd0);

        // Fresh sweep after the aborted one
        f_mode = 0;
        run_sweep(1, Gold, 1'b0, "post_rst");
        check_result("post_rst", 1'b1, 16'h7310, 5'd0, 4'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
